// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: load data returns 1 cycle after request, stores commit via a one-entry buffer.
// No backpressure: one request accepted every cycle; loads byte-merge with the pending store.
module data_sram_resp #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        acc_err,
  output logic [31:0] ld_cnt,
  output logic [31:0] st_cnt
);

  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];

  logic              r_sb_vld;
  logic [ADDR_W-1:0] r_sb_idx;
  logic [3:0]        r_sb_we;
  logic [31:0]       r_sb_wdata;

  logic [ADDR_W-1:0] w_idx;
  logic              w_inr;
  logic              w_is_ld;
  logic              w_is_st;
  logic              w_ld;
  logic              w_st;
  logic              w_oor;
  logic [31:0]       w_merged;
  logic              w_unused;

  assign w_idx    = data_sram_addr[ADDR_W+1:2];
  assign w_inr    = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign w_is_ld  = data_sram_en && (data_sram_we == 4'h0);
  assign w_is_st  = data_sram_en && (data_sram_we != 4'h0);
  assign w_ld     = w_is_ld && w_inr;
  assign w_st     = w_is_st && w_inr;
  assign w_oor    = data_sram_en && !w_inr;
  assign w_unused = &{1'b0, data_sram_addr[1:0]};

  // Array value is pre-commit; the buffered store overrides only its enabled bytes.
  always_comb begin
    w_merged = r_mem[w_idx];
    for (int i = 0; i < 4; i++) begin
      if (r_sb_vld && (r_sb_idx == w_idx) && r_sb_we[i]) begin
        w_merged[8*i +: 8] = r_sb_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && r_sb_vld) begin
      for (int i = 0; i < 4; i++) begin
        if (r_sb_we[i]) begin
          r_mem[r_sb_idx][8*i +: 8] <= r_sb_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_st) begin
      r_sb_idx   <= w_idx;
      r_sb_we    <= data_sram_we;
      r_sb_wdata <= data_sram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sb_vld        <= 1'b0;
      data_sram_rdata <= 32'h0;
      acc_err         <= 1'b0;
      ld_cnt          <= 32'h0;
      st_cnt          <= 32'h0;
    end else begin
      r_sb_vld <= w_st;
      acc_err  <= w_oor;
      if (w_ld) begin
        data_sram_rdata <= w_merged;
        ld_cnt          <= ld_cnt + 32'd1;
      end else if (w_is_ld) begin
        data_sram_rdata <= 32'h0;
      end
      if (w_st) begin
        st_cnt <= st_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: driver pushes expected responses, a negedge monitor pops and compares.
module tb_data_sram_resp;

  localparam logic [31:0] B = 32'h1c00_0000;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        acc_err;
  logic [31:0] ld_cnt;
  logic [31:0] st_cnt;

  int total = 0;
  int bad   = 0;

  exp_t        q[$];
  logic        due = 1'b0;
  logic [31:0] exp_last = 32'h0;
  logic [31:0] exp_ld = 32'h0;
  logic [31:0] exp_st = 32'h0;

  data_sram_resp dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .acc_err         (acc_err),
    .ld_cnt          (ld_cnt),
    .st_cnt          (st_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // A response is due after any accepted request edge.
  always @(posedge clk) due <= data_sram_en && resetn;

  always @(negedge clk) begin
    exp_t e;
    if (due) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got rdata %h with empty queue", data_sram_rdata);
      end else begin
        e = q.pop_front();
        chk("rdata", data_sram_rdata, e.rd);
        chk("acc_err", {31'h0, acc_err}, {31'h0, e.err});
      end
    end else if (resetn) begin
      chk("acc_err_idle", {31'h0, acc_err}, 32'h0);
    end
  end

  // Issue one request for one cycle; ld_exp is the expected load data (ignored for stores).
  task automatic req(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] ld_exp, input logic err);
    exp_t e;
    data_sram_en    = 1'b1;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    if (we == 4'h0) exp_last = ld_exp;
    if (!err && we == 4'h0) exp_ld = exp_ld + 32'd1;
    if (!err && we != 4'h0) exp_st = exp_st + 32'd1;
    e.rd  = exp_last;
    e.err = err;
    q.push_back(e);
    @(posedge clk); #1;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_cnt(input string tag);
    @(negedge clk);
    chk({tag, "_ld_cnt"}, ld_cnt, exp_ld);
    chk({tag, "_st_cnt"}, st_cnt, exp_st);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    idle(n);
    resetn   = 1'b1;
    exp_ld   = 32'h0;
    exp_st   = 32'h0;
    exp_last = 32'h0;
  endtask

  initial begin
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    do_reset(2);
    @(negedge clk);
    chk("reset_rdata", data_sram_rdata, 32'h0);
    chk("reset_acc_err", {31'h0, acc_err}, 32'h0);
    chk("reset_sb_vld", {31'h0, dut.r_sb_vld}, 32'h0);
    @(posedge clk); #1;
    chk_cnt("reset");

    // Preload words the later checks rely on, then reset (array contents survive)
    req(4'hF, B + 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0);
    req(4'hF, B + 32'h40, 32'h1122_3344, 32'h0, 1'b0);
    req(4'hF, B + 32'h08, 32'h0BAD_F00D, 32'h0, 1'b0);
    idle(2);
    do_reset(2);
    chk_cnt("after_reset");

    chk("rd_before_load", data_sram_rdata, 32'h0);
    req(4'h0, B + 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0);
    chk_cnt("first_load");

    req(4'hF, B + 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0);
    req(4'h0, B + 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0);
    chk_cnt("fwd");

    req(4'b0010, B + 32'h40, 32'hAAAA_AAAA, 32'h0, 1'b0);
    req(4'h0, B + 32'h40, 32'h0, 32'h1122_AA44, 1'b0);
    idle(2);
    req(4'h0, B + 32'h40, 32'h0, 32'h1122_AA44, 1'b0);

    req(4'hF, B + 32'h0, 32'h1, 32'h0, 1'b0);
    req(4'hF, B + 32'h4, 32'h2, 32'h0, 1'b0);
    req(4'hF, B + 32'h0, 32'h3, 32'h0, 1'b0);
    req(4'h0, B + 32'h0, 32'h0, 32'h3, 1'b0);
    req(4'h0, B + 32'h4, 32'h0, 32'h2, 1'b0);
    chk_cnt("b2b");

    req(4'hF, B + 32'h4000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    idle(1);
    req(4'h0, B + 32'h0, 32'h0, 32'h3, 1'b0);
    req(4'h0, B + 32'h4000, 32'h0, 32'h0, 1'b1);
    chk_cnt("oor");

    // en low with nonzero we must not store
    data_sram_we    = 4'hF;
    data_sram_addr  = B;
    data_sram_wdata = 32'h7777_7777;
    idle(1);
    data_sram_we = 4'h0;
    idle(1);
    req(4'h0, B + 32'h0, 32'h0, 32'h3, 1'b0);
    chk_cnt("en_low");

    // Store at the reset edge must be dropped
    data_sram_en    = 1'b1;
    data_sram_we    = 4'hF;
    data_sram_addr  = B + 32'h08;
    data_sram_wdata = 32'h5555_5555;
    resetn          = 1'b0;
    @(posedge clk); #1;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
    do_reset(1);
    @(negedge clk);
    chk("midrst_sb_vld", {31'h0, dut.r_sb_vld}, 32'h0);
    chk("midrst_rdata", data_sram_rdata, 32'h0);
    @(posedge clk); #1;
    chk_cnt("midrst");
    req(4'h0, B + 32'h08, 32'h0, 32'h0BAD_F00D, 1'b0);
    idle(2);
    chk_cnt("final");

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Data-side SRAM responder: the slave end of the execute stage's data_sram_en/we/addr/wdata port, returning data_sram_rdata to the memory stage one cycle later.
- Holds a word-addressed data memory with per-byte write enables.
- Stores pass through a one-entry store buffer and commit one cycle later, so the array write sits off the request-decode critical path. Reads are byte-merged with the buffer, so no stale data is ever visible.
- Also flags out-of-window accesses and keeps load/store debug counters.

Parameters:
- ADDR_W, 12: word-index width; memory depth is 2^ADDR_W words of 32 bits.
- BASE_ADDR, 32'h1c00_0000: window base; an access is in range iff addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- data_sram_en  in  1  request valid this cycle
- data_sram_we  in  4  byte write enables; nonzero = store, zero = load
- data_sram_addr  in  32  byte address; bits [1:0] ignored (initiator sends word-aligned)
- data_sram_wdata  in  32  store data, already lane-replicated by initiator
- data_sram_rdata  out  32  load data, valid the cycle after a load request
- acc_err  out  1  one-cycle pulse, the cycle after an out-of-window request
- ld_cnt  out  32  number of accepted in-range loads
- st_cnt  out  32  number of accepted in-range stores

Behaviour:
- Reset (resetn=0 at posedge): data_sram_rdata=0, acc_err=0, ld_cnt=0, st_cnt=0, sb_valid=0. Memory array contents are not reset. A store pending in the buffer at reset is dropped and never committed.
- Request decode, cycle N:
  - Load = en & we==0.
  - Store = en & we!=0.
  - en=0: no access, whatever we is.
  - idx = addr[ADDR_W+1:2]; inr = in-range per BASE_ADDR.
- Store buffer: one entry {sb_valid, sb_idx, sb_we, sb_wdata}.
  - Cycle N+1 commit: if sb_valid, each array byte i with sb_we[i]=1 at sb_idx is written from sb_wdata.
  - Cycle N+1 capture, same edge: an in-range store at N loads the buffer (sb_valid=1). Otherwise sb_valid=0.
  - Back-to-back stores are legal every cycle: the old entry commits while the new one is captured.
- Load, latency exactly 1:
  - At edge N+1, data_sram_rdata <= merged word.
  - Merged word byte i = sb_wdata byte i if sb_valid & sb_idx==idx & sb_we[i]; else array[idx] byte i as seen before this edge's commit.
  - A load is therefore never stale, including a load in the cycle right after a store to the same word (partial store merges only its enabled bytes).
  - Out-of-range load: rdata <= 32'h0.
- rdata holds its value on any cycle without a load, including store cycles.
- Out-of-range request (load or store, en=1, inr=0):
  - acc_err=1 for exactly one cycle at N+1.
  - A store is discarded: no buffer capture, no array change.
  - Counters are not incremented.
- Counters: ld_cnt++ on each in-range load; st_cnt++ on each in-range store. Both wrap modulo 2^32.
- No back-pressure: one request accepted per cycle, unconditionally.
- Array implementation: a register array, or an inferred RAM with equivalent read-before-write semantics plus the merge.

Test Plan:
- Reset then in-range load: resetn low 2 cycles; en=1, we=0, addr=BASE+0x10 -> rdata is 0 until the edge, then equals the preloaded word; ld_cnt=1, acc_err=0.
- Store-then-load forwarding: cycle N store we=4'hF, wdata=32'hDEAD_BEEF, addr=BASE+0x20; cycle N+1 load same addr -> rdata=32'hDEAD_BEEF at N+2; st_cnt=1, ld_cnt=1.
- Partial-byte merge: word BASE+0x40 holds 32'h1122_3344; store we=4'b0010, wdata=32'hAAAA_AAAA; next-cycle load -> rdata=32'h1122_AA44; load again 3 cycles later -> same value, now from the array.
- Back-to-back stores: stores to BASE+0x0 (0x1), BASE+0x4 (0x2), BASE+0x0 (0x3) in consecutive cycles, then loads of BASE+0x0 and BASE+0x4 -> 0x3 and 0x2.
- Out-of-range: store to BASE+(4<<ADDR_W) with wdata=0xFFFF_FFFF -> acc_err pulses 1 cycle, st_cnt unchanged, array word 0 unchanged; out-of-range load -> rdata=0 and acc_err pulse.
- Reset mid-operation: store 0x5555_5555 to BASE+0x8 in cycle N, resetn=0 at edge N+1 -> after reset, a load of BASE+0x8 returns its pre-store value; counters=0; sb_valid=0.
